// File: rtl/vec_cache_loader_if.sv
// Cache write-side types and the bundled command/beat/cache-write interface
// of the vector cache fill stage.
package vec_cache_pkg;

  typedef enum logic [1:0] {
    VEC_DATA_WRITE_DISABLE = 2'd0,
    VEC_DATA_WRITE_VEC     = 2'd1
  } VecDataWriteOp_t;

  // One vector lane, carried as the IEEE-754 single-precision (shortreal) bit pattern.
  typedef logic [31:0] lane_t;

endpackage

interface vec_cache_loader_if #(
  parameter int WIDTH      = 128,
  parameter int BEAT       = 8,
  parameter int CACHE_SIZE = 4
);
  localparam int AW = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1;
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [AW-1:0]                   cmd_addr;
  logic                            abort;
  logic                            in_valid;
  logic                            in_ready;
  vec_cache_pkg::lane_t [BEAT-1:0]  in_data;
  vec_cache_pkg::VecDataWriteOp_t  write_op;
  logic [AW-1:0]                   write_addr;
  logic [PW-1:0]                   write_param;
  vec_cache_pkg::lane_t [WIDTH-1:0] data_in;
  logic                            busy;
  logic                            done;

  modport master (
    output cmd_valid, cmd_addr, abort, in_valid, in_data,
    input  cmd_ready, in_ready, write_op, write_addr, write_param, data_in, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_addr, abort, in_valid, in_data,
    output cmd_ready, in_ready, write_op, write_addr, write_param, data_in, busy, done
  );

endinterface

// File: rtl/vec_cache_loader.sv
// Vector cache fill stage: takes a slot command, gathers NBEATS narrow beats
// into a staging buffer and commits the whole vector in one write cycle.
module vec_cache_loader #(
  parameter int WIDTH      = 128,
  parameter int BEAT       = 8,
  parameter int CACHE_SIZE = 4
) (
  input logic              clock,
  input logic              reset,
  vec_cache_loader_if.slave bus
);
  import vec_cache_pkg::*;

  localparam int NBEATS = WIDTH / BEAT;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int AW     = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  generate
    if ((WIDTH % BEAT) != 0) begin : g_beat_check
      $error("vec_cache_loader: WIDTH must be a multiple of BEAT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              cmd_take;
  logic              beat_take;
  logic [IDX_W-1:0]  beat_idx;
  logic [AW-1:0]     addr_q;
  lane_t [WIDTH-1:0] buffer;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs decode from state only; abort alone may gate in_ready.
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt     = state;
    cmd_take      = 1'b0;
    beat_take     = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    bus.write_op  = VEC_DATA_WRITE_DISABLE;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cmd_take  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        bus.in_ready = !bus.abort;
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (bus.in_valid) begin
          beat_take = 1'b1;
          if (beat_idx == LAST_IDX) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        bus.done     = 1'b1;
        bus.write_op = VEC_DATA_WRITE_VEC;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the staging buffer is reset like any register, since its contents
  // are visible on data_in and must read 0.0 out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_idx <= '0;
      addr_q   <= '0;
      buffer   <= '0;
    end else begin
      if (cmd_take) begin
        addr_q   <= bus.cmd_addr;
        beat_idx <= '0;
      end
      if (beat_take) begin
        for (int b = 0; b < NBEATS; b++) begin
          if (beat_idx == IDX_W'(b)) buffer[b*BEAT +: BEAT] <= bus.in_data;
        end
        // The last beat moves to COMMIT instead, so the index never wraps.
        if (beat_idx != LAST_IDX) beat_idx <= beat_idx + 1'b1;
      end
    end
  end

  assign bus.write_addr  = addr_q;
  assign bus.write_param = '0;
  assign bus.data_in     = buffer;

endmodule

// File: tb/tb_vec_cache_loader.sv
// Randomized and directed bench for vec_cache_loader against a transaction-level
// model of the load/commit/abort rules and a shadow of the cache contents.
`timescale 1ns/1ps
module tb_vec_cache_loader;
  import vec_cache_pkg::*;

  localparam int WIDTH      = 16;
  localparam int BEAT       = 4;
  localparam int CACHE_SIZE = 4;
  localparam int NB         = WIDTH / BEAT;
  localparam int BEAT1      = 16;

  typedef lane_t [BEAT-1:0]  beat_t;
  typedef lane_t [WIDTH-1:0] vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vec_cache_loader_if #(.WIDTH(WIDTH), .BEAT(BEAT),  .CACHE_SIZE(CACHE_SIZE)) bus ();
  vec_cache_loader_if #(.WIDTH(WIDTH), .BEAT(BEAT1), .CACHE_SIZE(CACHE_SIZE)) bus1 ();

  vec_cache_loader #(.WIDTH(WIDTH), .BEAT(BEAT), .CACHE_SIZE(CACHE_SIZE)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  vec_cache_loader #(.WIDTH(WIDTH), .BEAT(BEAT1), .CACHE_SIZE(CACHE_SIZE)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a load is either idle, collecting m_got beats, or committing.
  bit         m_load;
  bit         m_commit;
  int         m_got;
  logic [1:0] m_addr;
  vec_t       m_buf;
  vec_t       ref_cache [CACHE_SIZE];
  vec_t       dut_cache [CACHE_SIZE];
  int         cyc        = 0;
  int         acc_cyc    = -1;
  int         commit_cyc = -1;
  int         n_commits  = 0;

  task automatic model_reset();
    m_load   = 0;
    m_commit = 0;
    m_got    = 0;
    m_addr   = '0;
    m_buf    = '0;
  endtask

  task automatic model_update();
    if (m_commit) begin
      ref_cache[m_addr] = m_buf;
      m_commit = 0;
    end else if (m_load) begin
      if (bus.abort) begin
        m_load = 0;
      end else if (bus.in_valid) begin
        for (int k = 0; k < BEAT; k++) m_buf[m_got*BEAT + k] = bus.in_data[k];
        m_got++;
        if (m_got == NB) begin
          m_load   = 0;
          m_commit = 1;
        end
      end
    end else if (bus.cmd_valid) begin
      m_load  = 1;
      m_got   = 0;
      m_addr  = bus.cmd_addr;
      acc_cyc = cyc;
    end
  endtask

  task automatic check_outputs();
    check("cmd_ready",   bus.cmd_ready,   !m_load && !m_commit);
    check("in_ready",    bus.in_ready,    m_load && !bus.abort);
    check("busy",        bus.busy,        m_load || m_commit);
    check("done",        bus.done,        m_commit);
    check("write_op",    bus.write_op,    m_commit ? VEC_DATA_WRITE_VEC : VEC_DATA_WRITE_DISABLE);
    check("write_addr",  bus.write_addr,  m_addr);
    check("write_param", bus.write_param, '0);
    check("data_in",     bus.data_in,     m_buf);
  endtask

  // One clock: check outputs mid-cycle, capture any cache write, advance the model.
  task automatic step();
    #1;
    check_outputs();
    if (bus.write_op == VEC_DATA_WRITE_VEC && !$isunknown(bus.write_addr)) begin
      dut_cache[bus.write_addr] = bus.data_in;
      commit_cyc = cyc + 1;
      n_commits++;
    end
    @(posedge clock);
    cyc++;
    model_update();
    @(negedge clock);
  endtask

  task automatic drive(bit cv, logic [1:0] ca, bit ab, bit iv, beat_t d);
    bus.cmd_valid = cv;
    bus.cmd_addr  = ca;
    bus.abort     = ab;
    bus.in_valid  = iv;
    bus.in_data   = d;
  endtask

  function automatic beat_t rand_beat();
    beat_t d;
    for (int k = 0; k < BEAT; k++) d[k] = $urandom;
    return d;
  endfunction

  // Bit pattern of a small non-negative integer as a shortreal.
  function automatic lane_t to_float(int n);
    int msb = 0;
    if (n == 0) return 32'h0;
    for (int i = 0; i < 31; i++) if (n[i]) msb = i;
    return {1'b0, 8'(127 + msb), 23'((n << (23 - msb)) & 32'h007F_FFFF)};
  endfunction

  // Full load of vector v into slot a, with stall_len idle beats after beat stall_after.
  task automatic load(logic [1:0] a, vec_t v, int stall_after, int stall_len);
    beat_t d;
    drive(1, a, 0, 0, '0);
    step();
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < BEAT; k++) d[k] = v[b*BEAT + k];
      drive(0, '0, 0, 1, d);
      step();
      if (b == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          drive(0, '0, 0, 0, rand_beat());
          #1 check("stall_in_ready", bus.in_ready, 1'b1);
          step();
        end
      end
    end
    drive(0, '0, 0, 0, '0);
    step();
  endtask

  initial begin : main
    vec_t  v;
    beat_t d;
    int    c1;
    int    base;
    for (int i = 0; i < CACHE_SIZE; i++) begin
      ref_cache[i] = '0;
      dut_cache[i] = '0;
    end
    model_reset();
    reset = 1'b1;
    drive(0, '0, 0, 0, '0);
    bus1.cmd_valid = 1'b0;
    bus1.cmd_addr  = '0;
    bus1.abort     = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;

    // Reset values on both instances.
    @(negedge clock);
    check_outputs();
    check("rst_beat_idx", dut.beat_idx, '0);
    check("rst1_cmd_ready", bus1.cmd_ready, 1'b1);
    check("rst1_data_in", bus1.data_in, '0);
    reset = 1'b0;
    step();

    // Basic load: lanes i.0 into slot 2, commit at cycle 5.
    for (int i = 0; i < WIDTH; i++) v[i] = to_float(i);
    load(2'd2, v, -1, 0);
    check("s1_latency", commit_cyc - acc_cyc, 5);
    check("s1_cache", dut_cache[2], v);
    check("s1_lane1", dut_cache[2][1], 32'h3F80_0000);
    check("s1_lane15", dut_cache[2][15], 32'h4170_0000);
    check("s1_ready_after", bus.cmd_ready, 1'b1);

    // Stalled input: 3 idle cycles after beat 1, commit at cycle 8.
    for (int i = 0; i < WIDTH; i++) v[i] = $urandom;
    load(2'd2, v, 1, 3);
    check("s2_latency", commit_cyc - acc_cyc, 8);
    check("s2_cache", dut_cache[2], v);

    // Abort after two beats of 1.0, then a normal load to slot 1.
    base = n_commits;
    for (int k = 0; k < BEAT; k++) d[k] = 32'h3F80_0000;
    drive(1, 2'd3, 0, 0, '0);
    step();
    drive(0, '0, 0, 1, d);
    step();
    step();
    drive(0, '0, 1, 1, rand_beat());
    step();
    drive(0, '0, 0, 0, '0);
    check("s3_ready_after_abort", bus.cmd_ready, 1'b1);
    check("s3_partial_lanes", bus.data_in[7:0], {8{32'h3F80_0000}});
    step();
    check("s3_no_write", n_commits - base, 0);
    for (int i = 0; i < WIDTH; i++) v[i] = $urandom;
    load(2'd1, v, -1, 0);
    check("s3_second_commit", n_commits - base, 1);
    check("s3_cache", dut_cache[1], v);

    // Back-to-back commands with cmd_valid held high.
    drive(1, 2'd0, 0, 0, '0);
    step();
    for (int b = 0; b < NB; b++) begin
      drive(1, 2'd3, 0, 1, rand_beat());
      step();
    end
    drive(1, 2'd3, 0, 0, '0);
    step();
    c1 = commit_cyc;
    step();
    for (int b = 0; b < NB; b++) begin
      drive(0, '0, 0, 1, rand_beat());
      step();
    end
    drive(0, '0, 0, 0, '0);
    step();
    check("s4_spacing", commit_cyc - c1, 6);

    // Async reset between edges during FILL.
    base = n_commits;
    drive(1, 2'd2, 0, 0, '0);
    step();
    for (int b = 0; b < 2; b++) begin
      drive(0, '0, 0, 1, rand_beat());
      step();
    end
    drive(0, '0, 0, 1, rand_beat());
    #2 reset = 1'b1;
    #1;
    check("s5_busy", bus.busy, 1'b0);
    check("s5_data_in", bus.data_in, '0);
    check("s5_cmd_ready", bus.cmd_ready, 1'b1);
    check("s5_write_op", bus.write_op, VEC_DATA_WRITE_DISABLE);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(0, '0, 0, 0, '0);
    for (int i = 0; i < 6; i++) step();
    check("s5_no_commit", n_commits - base, 0);

    // One-beat instance: commit at cycle 2, beat_idx pinned to 0.
    for (int i = 0; i < WIDTH; i++) v[i] = $urandom;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_addr  = 2'd1;
    step();
    base = cyc;
    bus1.cmd_valid = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = v;
    #1 check("s6_in_ready", bus1.in_ready, 1'b1);
    check("s6_beat_idx_fill", dut1.beat_idx, '0);
    step();
    bus1.in_valid = 1'b0;
    #1;
    check("s6_write_op", bus1.write_op, VEC_DATA_WRITE_VEC);
    check("s6_done", bus1.done, 1'b1);
    check("s6_addr", bus1.write_addr, 2'd1);
    check("s6_data", bus1.data_in, v);
    check("s6_latency", cyc + 1 - base, 2);
    check("s6_beat_idx_commit", dut1.beat_idx, '0);
    step();
    check("s6_ready_after", bus1.cmd_ready, 1'b1);
    check("s6_busy_after", bus1.busy, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 1), 2'($urandom_range(0, CACHE_SIZE - 1)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, rand_beat());
      step();
    end
    drive(0, '0, 0, 0, '0);
    for (int i = 0; i < NB + 4; i++) step();
    for (int i = 0; i < CACHE_SIZE; i++) check($sformatf("cache_slot%0d", i), dut_cache[i], ref_cache[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
